// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller: phase codes, lamp
// encodings and the lamp decode used by the phase sequencer.
package tlc_pkg;

  typedef enum logic [3:0] {
    MAIN_GRN  = 4'd0,
    MAIN_YEL  = 4'd1,
    ALL_RED_A = 4'd2,
    SIDE_GRN  = 4'd3,
    SIDE_YEL  = 4'd4,
    ALL_RED_B = 4'd5,
    PED_WALK  = 4'd6
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int TB_TICK_DIV = 4;

  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk;
  } lamps_t;

  // Any code without a green or yellow phase, including illegal ones, is all-red.
  function automatic lamps_t decode_lamps(input logic [3:0] code);
    lamps_t l;
    l = '{main_l: LAMP_RED, side_l: LAMP_RED, walk: 1'b0};
    case (code)
      MAIN_GRN: l.main_l = LAMP_GRN;
      MAIN_YEL: l.main_l = LAMP_YEL;
      SIDE_GRN: l.side_l = LAMP_GRN;
      SIDE_YEL: l.side_l = LAMP_YEL;
      PED_WALK: l.walk   = 1'b1;
      default:  l        = l;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle
// tick. A synchronous clear restarts the count so each phase starts a fresh period.
module tlc_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Phase register, dwell timer, request synchronizers and registered lamp decode
// for the traffic-light controller.
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GREEN_MIN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int SIDE_T    = 8,
  parameter int WALK_T    = 6
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       w,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [3:0] phase
);

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] SIDE_LAST   = 8'(SIDE_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

  logic       w_meta, w_sync;
  logic       ped_meta, ped_sync, ped_sync_q;
  logic       ped_rise, ped_pending;
  logic       tick, phase_change, enter_walk;
  logic [7:0] dwell;
  phase_t     state, next_phase;
  lamps_t     next_lamps;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (Clock),
    .rst_n (Resetn),
    .clear (phase_change),
    .tick  (tick)
  );

  assign ped_rise = ped_sync & ~ped_sync_q;

  // NOTE: next_phase is given a default before the case so no path leaves it
  // unassigned; that is what keeps always_comb from inferring a latch.
  always_comb begin
    next_phase = state;
    case (state)
      MAIN_GRN:  if (tick && dwell >= GREEN_LAST && (w_sync || ped_pending)) next_phase = MAIN_YEL;
      MAIN_YEL:  if (tick && dwell == YELLOW_LAST) next_phase = ALL_RED_A;
      ALL_RED_A: if (tick && dwell == ALLRED_LAST) next_phase = SIDE_GRN;
      SIDE_GRN:  if (tick && dwell == SIDE_LAST)   next_phase = SIDE_YEL;
      SIDE_YEL:  if (tick && dwell == YELLOW_LAST) next_phase = ALL_RED_B;
      ALL_RED_B: if (tick && dwell == ALLRED_LAST) next_phase = ped_pending ? PED_WALK : MAIN_GRN;
      PED_WALK:  if (tick && dwell == WALK_LAST)   next_phase = MAIN_GRN;
      default:   next_phase = ALL_RED_B;
    endcase
  end

  assign phase_change = (next_phase != state);
  assign enter_walk   = phase_change && (next_phase == PED_WALK);
  assign next_lamps   = decode_lamps(next_phase);
  assign phase        = state;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      w_meta      <= 1'b0;
      w_sync      <= 1'b0;
      ped_meta    <= 1'b0;
      ped_sync    <= 1'b0;
      ped_sync_q  <= 1'b0;
      ped_pending <= 1'b0;
      dwell       <= '0;
    end else begin
      w_meta     <= w;
      w_sync     <= w_meta;
      ped_meta   <= ped_req;
      ped_sync   <= ped_meta;
      ped_sync_q <= ped_sync;
      // A press landing on the walk-entry edge is kept for the next cycle.
      if (ped_rise) begin
        ped_pending <= 1'b1;
      end else if (enter_walk) begin
        ped_pending <= 1'b0;
      end
      if (phase_change) begin
        dwell <= '0;
      end else if (tick && dwell != 8'hFF) begin
        dwell <= dwell + 8'd1;
      end
    end
  end

  // Lamps are registered from next_phase so they change on the same edge as phase.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ALL_RED_B;
      main_light <= LAMP_RED;
      side_light <= LAMP_RED;
      walk       <= 1'b0;
    end else begin
      state      <= next_phase;
      main_light <= next_lamps.main_l;
      side_light <= next_lamps.side_l;
      walk       <= next_lamps.walk;
    end
  end

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: expected phase segments are queued as stimulus
// is applied and matched against the observed phase runs by a monitor.
module tb_tlc_phase_sequencer;
  import tlc_pkg::*;

  logic       Clock, Resetn, w, ped_req, walk;
  logic [2:0] main_light, side_light;
  logic [3:0] phase;

  tlc_phase_sequencer #(
    .TICK_DIV(TB_TICK_DIV), .GREEN_MIN(10), .YELLOW_T(3),
    .ALLRED_T(1), .SIDE_T(8), .WALK_T(6)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .w(w), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk), .phase(phase)
  );

  typedef struct {
    logic [3:0] ph;
    int         len;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
  } seg_t;

  seg_t vec [20];
  seg_t exp_q [$];
  int   tests = 0;
  int   fails = 0;

  logic [3:0] cur_ph;
  int         cur_len;
  bit         cur_valid;
  logic [6:0] seg_out;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lamp table written from the phase/lamp definitions, independent of the RTL.
  function automatic logic [6:0] lamp_model(input logic [3:0] p);
    case (p)
      4'd0:    return {3'b001, 3'b100, 1'b0};
      4'd1:    return {3'b010, 3'b100, 1'b0};
      4'd3:    return {3'b100, 3'b001, 1'b0};
      4'd4:    return {3'b100, 3'b010, 1'b0};
      4'd6:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  function automatic seg_t seg(input logic [3:0] p, input int len);
    seg_t s;
    s.ph = p;
    s.len = len;
    {s.main_l, s.side_l, s.walk_l} = lamp_model(p);
    return s;
  endfunction

  // Monitor: per-cycle lamp checks, and segment (phase, length) scoreboard.
  initial begin
    seg_t e;
    cur_valid = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        cur_valid = 1'b0;
      end else begin
        check("lamp_onehot", {30'd0, $countones(main_light) == 1, $countones(side_light) == 1}, 32'd3);
        check("lamp_decode", {25'd0, main_light, side_light, walk}, {25'd0, lamp_model(phase)});
        if (cur_valid && phase != cur_ph) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg_phase", {28'd0, cur_ph}, {28'd0, e.ph});
            check("seg_len", cur_len, e.len);
            check("seg_lamps", {25'd0, seg_out}, {25'd0, e.main_l, e.side_l, e.walk_l});
          end
          cur_valid = 1'b0;
        end
        if (!cur_valid) begin
          cur_valid = 1'b1;
          cur_ph    = phase;
          cur_len   = 1;
          seg_out   = {main_light, side_light, walk};
        end else begin
          cur_len++;
        end
      end
    end
  end

  task automatic do_reset(input logic w_val);
    exp_q.delete();
    Resetn  = 1'b0;
    w       = w_val;
    ped_req = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
  endtask

  task automatic push_vec(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(vec[i]);
  endtask

  task automatic wait_phase(input logic [3:0] p, input int budget, input string name);
    int n = 0;
    while (phase !== p && n < budget) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check(name, {28'd0, phase}, {28'd0, p});
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;

    // Full lap with w held high, ending in a second main green.
    vec[0]  = seg(ALL_RED_B, 4);
    vec[1]  = seg(MAIN_GRN, 40);
    vec[2]  = seg(MAIN_YEL, 12);
    vec[3]  = seg(ALL_RED_A, 4);
    vec[4]  = seg(SIDE_GRN, 32);
    vec[5]  = seg(SIDE_YEL, 12);
    vec[6]  = seg(ALL_RED_B, 4);
    vec[7]  = seg(MAIN_GRN, 40);
    // Pedestrian press during side green.
    vec[8]  = seg(SIDE_GRN, 32);
    vec[9]  = seg(SIDE_YEL, 12);
    vec[10] = seg(ALL_RED_B, 4);
    vec[11] = seg(PED_WALK, 24);
    // Press on the walk-entry edge: a second walk follows the next lap.
    vec[12] = seg(PED_WALK, 24);
    vec[13] = seg(MAIN_GRN, 40);
    vec[14] = seg(MAIN_YEL, 12);
    vec[15] = seg(ALL_RED_A, 4);
    vec[16] = seg(SIDE_GRN, 32);
    vec[17] = seg(SIDE_YEL, 12);
    vec[18] = seg(ALL_RED_B, 4);
    vec[19] = seg(PED_WALK, 24);

    // Asynchronous reset before any clock edge.
    Resetn = 1'b1; w = 1'b0; ped_req = 1'b0;
    #1 Resetn = 1'b0;
    #1;
    check("reset_phase", {28'd0, phase}, 32'd5);
    check("reset_lamps", {25'd0, main_light, side_light, walk}, {25'd0, 3'b100, 3'b100, 1'b0});

    // Scenario 1: no requests, main green holds.
    do_reset(1'b0);
    push_vec(0, 0);
    drain(20, "s1_drain");
    repeat (2000) @(negedge Clock);
    #1;
    check("s1_hold_phase", {28'd0, cur_ph}, 32'd0);
    check("s1_hold_len", cur_len, 2001);

    // Scenario 2: w held high from reset.
    do_reset(1'b1);
    push_vec(0, 7);
    drain(300, "s2_drain");

    // Scenario 3: one-cycle ped_req during side green.
    do_reset(1'b1);
    wait_phase(SIDE_GRN, 200, "s3_reach_side");
    w = 1'b0;
    ped_req = 1'b1;
    @(negedge Clock);
    ped_req = 1'b0;
    push_vec(8, 11);
    drain(200, "s3_drain");
    check("s3_end_phase", {28'd0, phase}, 32'd0);
    check("s3_pending_clear", {31'd0, dut.ped_pending}, 32'd0);

    // Scenario 4: w rises well into main green.
    do_reset(1'b0);
    wait_phase(MAIN_GRN, 20, "s4_reach_main");
    repeat (200) @(negedge Clock);
    w = 1'b1;
    n = 0;
    while (phase !== 4'd1 && n < 50) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check("s4_latency_in_3_to_6", {31'd0, n >= 3 && n <= 6}, 32'd1);

    // Scenario 5: reset pulsed mid side green acts without a clock edge.
    wait_phase(SIDE_GRN, 200, "s5_reach_side");
    repeat (10) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("s5_async_phase", {28'd0, phase}, 32'd5);
    check("s5_async_lamps", {25'd0, main_light, side_light, walk}, {25'd0, 3'b100, 3'b100, 1'b0});
    do_reset(1'b0);
    push_vec(0, 0);
    drain(20, "s5_drain");
    check("s5_restart_main", {28'd0, phase}, 32'd0);

    // Scenario 6: ped_req rising edge lands on the walk-entry edge.
    do_reset(1'b1);
    wait_phase(MAIN_GRN, 20, "s6_reach_main");
    ped_req = 1'b1;
    @(negedge Clock);
    ped_req = 1'b0;
    wait_phase(SIDE_YEL, 200, "s6_reach_side_yel");
    wait_phase(ALL_RED_B, 50, "s6_reach_all_red_b");
    @(negedge Clock);
    ped_req = 1'b1;
    wait_phase(PED_WALK, 10, "s6_reach_walk");
    check("s6_pending_kept", {31'd0, dut.ped_pending}, 32'd1);
    ped_req = 1'b0;
    push_vec(12, 19);
    drain(400, "s6_drain");
    w = 1'b0;
    check("s6_pending_clear", {31'd0, dut.ped_pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
